// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Instruction shown to IF/ID when the fetch buffer is empty (addi x0, x0, 0).
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // PC of the first fetch after reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Request FSM: idle, one request whose data is kept, one request whose data is dropped.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    // One fetch-buffer entry: instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are always zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch side: issues requests, receives responses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {inst, pc} sitting between instruction memory and IF/ID.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output logic [1:0]   o_count,
    output logic [31:0]  o_head_inst,
    output logic [31:0]  o_head_pc
);

    logic [1:0]   r_count;
    fetch_entry_t r_entry0;
    fetch_entry_t r_entry1;

    // Occupancy: clear wins, then push/pop adjust the count (push+pop leaves it unchanged).
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage: entry0 is the head; a pop shifts entry1 forward, a push fills the first free slot.
    // NOTE: the data entries have no reset; they are only observed when r_count says they are valid.
    always_ff @(posedge clk) begin
        if (!i_clear) begin
            if (i_pop && i_push) begin
                if (r_count == 2'd2) begin
                    r_entry0 <= r_entry1;
                    r_entry1 <= i_data;
                end else begin
                    r_entry0 <= i_data;
                end
            end else if (i_pop) begin
                r_entry0 <= r_entry1;
            end else if (i_push) begin
                if (r_count == 2'd0) begin
                    r_entry0 <= i_data;
                end else begin
                    r_entry1 <= i_data;
                end
            end
        end
    end

    assign o_count     = r_count;
    assign o_head_inst = r_entry0.inst;
    assign o_head_pc   = r_entry0.pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// buffers responses and presents the buffer head to the IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    fetch_if.master      imem,
    output logic [31:0]  inst_out,
    output logic [31:0]  PC_out,
    output logic         valid_out
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;

    logic [1:0]   w_count;
    logic [31:0]  w_head_inst;
    logic [31:0]  w_head_pc;
    logic         w_valid;
    logic         w_pop;
    logic         w_push;
    logic         w_issue;
    fetch_entry_t w_push_data;

    assign w_valid = (w_count != 2'd0);

    // Pop/push qualification; a redirect suppresses both since the buffer is being flushed.
    assign w_pop       = w_valid && !stall_i && !redirect_i;
    assign w_push      = (r_state == S_WAIT) && imem.imem_rvalid && !redirect_i;
    assign w_push_data = '{inst: imem.imem_rdata, pc: r_req_pc};

    // Issue decision: only ever request when a buffer slot is guaranteed for the response.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_issue = 1'b0;
        if (rst && !redirect_i) begin
            unique case (r_state)
                S_REQ:   w_issue = (w_count < 2'd2);
                S_WAIT:  w_issue = imem.imem_rvalid &&
                                   ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));
                default: w_issue = 1'b0;
            endcase
        end
    end

    // Request FSM and PC bookkeeping; a redirect overrides everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_REQ;
            r_pc     <= align_pc(RESET_PC);
            r_req_pc <= 32'h0;
        end else if (redirect_i) begin
            r_pc <= align_pc(redirect_pc_i);
            unique case (r_state)
                S_WAIT:  r_state <= imem.imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  r_state <= imem.imem_rvalid ? S_REQ : S_DROP;
                default: r_state <= S_REQ;
            endcase
        end else begin
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            unique case (r_state)
                S_REQ: begin
                    if (w_issue) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) r_state <= w_issue ? S_WAIT : S_REQ;
                end
                S_DROP: begin
                    if (imem.imem_rvalid) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    fetch_buffer u_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (redirect_i),
        .i_data      (w_push_data),
        .o_count     (w_count),
        .o_head_inst (w_head_inst),
        .o_head_pc   (w_head_pc)
    );

    assign imem.imem_req  = w_issue;
    assign imem.imem_addr = r_pc;

    assign valid_out = w_valid;
    assign inst_out  = w_valid ? w_head_inst : NOP_INST;
    assign PC_out    = w_valid ? w_head_pc   : 32'h0;

endmodule
